ecall_service_unit: RTL and testbench

- Responder side of the `ECALL` path. The main controller only flags `ecall`; this block services the call, stalls the single-cycle core while the call is in progress, and returns results to the register file.
- Service code is taken from a7 (x17) and the argument from a0 (x10).
- Sits between the core datapath, the register-file write port (a0 writeback) and the board I/O (switches, confirm button, LED/7-seg display register).

---
 rtl/ecall_service_if.sv | 26 ++
 rtl/ecall_service_unit.sv | 74 +++++++
 tb/tb_ecall_service_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ecall_service_if.sv
// ecall_service_if: core/board-side signals of the ECALL responder
interface ecall_service_if #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 16
);
  logic              ecall;
  logic [DATA_W-1:0] a7_val;
  logic [DATA_W-1:0] a0_val;
  logic [SW_W-1:0]   sw_in;
  logic              confirm;
  logic              stall;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] disp_val;
  logic              disp_upd;
  logic              waiting_input;
  logic              halted;
  modport slave (
    input  ecall, a7_val, a0_val, sw_in, confirm,
    output stall, wb_en, wb_data, disp_val, disp_upd, waiting_input, halted
  );
  modport master (
    output ecall, a7_val, a0_val, sw_in, confirm,
    input  stall, wb_en, wb_data, disp_val, disp_upd, waiting_input, halted
  );
endinterface

// File: rtl/ecall_service_unit.sv
// ecall_service_unit: services print/read/exit ECALLs, stalling the core while busy
module ecall_service_unit #(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 16,
  parameter int CODE_PRINT = 1,
  parameter int CODE_READ  = 5,
  parameter int CODE_EXIT  = 10,
  parameter bit SIGN_EXT   = 1'b0
) (
  input logic clk,
  input logic rst,
  ecall_service_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_IN, DONE, HALT} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] code_q;
  logic [DATA_W-1:0] disp_q;
  logic [DATA_W-1:0] wb_q;
  logic              upd_q;
  logic              halted_q;
  logic [DATA_W-1:0] sw_ext;
  logic              is_print;
  logic              is_read;
  logic              is_exit;
  // Size casts are self-determined, so the signed cast sign-extends the switches
  assign sw_ext   = SIGN_EXT ? DATA_W'($signed(bus.sw_in)) : DATA_W'(bus.sw_in);
  assign is_print = bus.a7_val == DATA_W'(CODE_PRINT);
  assign is_read  = bus.a7_val == DATA_W'(CODE_READ);
  assign is_exit  = bus.a7_val == DATA_W'(CODE_EXIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      disp_q   <= '0;
      wb_q     <= '0;
      upd_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.ecall) begin
          code_q <= bus.a7_val;
          if (is_print) begin
            disp_q  <= bus.a0_val;
            upd_q   <= 1'b1;
            state_q <= DONE;
          end else if (is_read) begin
            state_q <= WAIT_IN;
          end else if (is_exit) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            state_q <= DONE;
          end
        end
        WAIT_IN: if (bus.confirm) begin
          wb_q    <= sw_ext;
          state_q <= DONE;
        end
        DONE: begin
          upd_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= HALT;
      endcase
    end
  end
  assign bus.stall         = (state_q == IDLE && bus.ecall) || state_q == WAIT_IN || state_q == HALT;
  assign bus.wb_en         = state_q == DONE && code_q == DATA_W'(CODE_READ);
  assign bus.wb_data       = wb_q;
  assign bus.disp_val      = disp_q;
  assign bus.disp_upd      = upd_q;
  assign bus.waiting_input = state_q == WAIT_IN;
  assign bus.halted        = halted_q;
endmodule

// File: tb/tb_ecall_service_unit.sv
// tb_ecall_service_unit: random + directed check of both extension variants against a call-level model
module tb_ecall_service_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ecall = 1'b0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic [15:0] sw = '0;
  logic        confirm = 1'b0;
  int          total = 0;
  int          bad = 0;
  // model: what the responder is busy with, expressed as call-level facts
  bit          m_reading, m_finishing, m_read_result, m_exited, m_upd;
  logic [31:0] m_disp, m_wb_z, m_wb_s;
  int          halt_cycles;

  ecall_service_if #(.DATA_W(32), .SW_W(16)) bz ();
  ecall_service_if #(.DATA_W(32), .SW_W(16)) bs ();
  ecall_service_unit #(.SIGN_EXT(1'b0)) dut_z (.clk(clk), .rst(rst), .bus(bz));
  ecall_service_unit #(.SIGN_EXT(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs));
  assign bz.ecall = ecall;
  assign bz.a7_val = a7;
  assign bz.a0_val = a0;
  assign bz.sw_in = sw;
  assign bz.confirm = confirm;
  assign bs.ecall = ecall;
  assign bs.a7_val = a7;
  assign bs.a0_val = a0;
  assign bs.sw_in = sw;
  assign bs.confirm = confirm;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_reading = 0; m_finishing = 0; m_read_result = 0; m_exited = 0; m_upd = 0;
    m_disp = '0; m_wb_z = '0; m_wb_s = '0;
  endtask

  task automatic compare_all();
    logic exp_stall;
    exp_stall = m_exited || m_reading || (!m_finishing && ecall);
    chk("stall_z", 32'(bz.stall), 32'(exp_stall));
    chk("stall_s", 32'(bs.stall), 32'(exp_stall));
    chk("wb_en_z", 32'(bz.wb_en), 32'(m_finishing && m_read_result));
    chk("wb_en_s", 32'(bs.wb_en), 32'(m_finishing && m_read_result));
    chk("wb_data_z", bz.wb_data, m_wb_z);
    chk("wb_data_s", bs.wb_data, m_wb_s);
    chk("disp_val", bz.disp_val, m_disp);
    chk("disp_val_s", bs.disp_val, m_disp);
    chk("disp_upd", 32'(bz.disp_upd), 32'(m_upd));
    chk("waiting", 32'(bz.waiting_input), 32'(m_reading));
    chk("halted", 32'(bz.halted), 32'(m_exited));
    chk("halted_s", 32'(bs.halted), 32'(m_exited));
  endtask

  // called at negedge with inputs already applied
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    m_upd = 0;
    if (m_exited) begin
    end else if (m_finishing) begin
      m_finishing = 0;
      m_read_result = 0;
    end else if (m_reading) begin
      if (confirm) begin
        m_wb_z = {16'h0, sw};
        m_wb_s = {{16{sw[15]}}, sw};
        m_reading = 0;
        m_finishing = 1;
        m_read_result = 1;
      end
    end else if (ecall) begin
      if (a7 == 32'd1) begin m_disp = a0; m_upd = 1; m_finishing = 1; end
      else if (a7 == 32'd5) m_reading = 1;
      else if (a7 == 32'd10) m_exited = 1;
      else m_finishing = 1;
    end
    @(negedge clk);
  endtask

  // asynchronous assertion away from any clock edge, released at a negedge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_clear();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic call(input logic [31:0] code, input logic [31:0] arg);
    ecall = 1'b1; a7 = code; a0 = arg;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    // print 0x2A; ecall held through the completion cycle
    call(32'd1, 32'h2A); tick(); tick();
    ecall = 1'b0; tick();
    // read with long hold, then confirm
    call(32'd5, '0); tick();
    for (int i = 0; i < 20; i++) tick();
    sw = 16'h8001; confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    ecall = 1'b0; tick();
    // stray confirm while idle must not complete a later read
    confirm = 1'b1; tick();
    confirm = 1'b0; call(32'd5, '0); tick();
    for (int i = 0; i < 5; i++) tick();
    sw = 16'h1234; confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    ecall = 1'b0; tick();
    // unknown code, then back-to-back print
    call(32'd7, 32'h55); tick(); tick();
    call(32'd1, 32'hFFFF_FFFF); tick(); tick();
    ecall = 1'b0; tick();
    // async reset in the middle of a read
    call(32'd5, '0); tick(); tick();
    do_reset();
    ecall = 1'b0; tick();
    // exit, then hammer inputs
    call(32'd10, '0); tick();
    for (int i = 0; i < 110; i++) begin
      ecall = 1'($urandom); confirm = 1'($urandom); a7 = 32'($urandom_range(0, 12));
      tick();
    end
    do_reset();
    // ecall present at reset release is serviced at the first clock
    call(32'd1, 32'hCAFE); tick(); tick();
    // random traffic
    halt_cycles = 0;
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 19);
      ecall = ($urandom_range(0, 9) < 6);
      a7 = r < 6 ? 32'd1 : r < 11 ? 32'd5 : r == 11 ? 32'd10 : 32'($urandom);
      a0 = 32'($urandom);
      sw = 16'($urandom);
      confirm = ($urandom_range(0, 9) < 2);
      tick();
      halt_cycles = m_exited ? halt_cycles + 1 : 0;
      if (halt_cycles > 15 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
